// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared constants and types for the reorder buffer
package reorder_buffer_pkg;

  localparam int NUM_FU        = 2;
  localparam int NUM_PHYS_REG  = 64;
  localparam int NUM_FLAGS     = 4;
  localparam int ROB_DEPTH_DEF = 32;

  localparam int PHYS_W        = $clog2(NUM_PHYS_REG);
  localparam int ROB_IDX_W_DEF = $clog2(ROB_DEPTH_DEF);

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 dest_v;
    logic [PHYS_W-1:0]    phys_new;
    logic [PHYS_W-1:0]    phys_old;
    logic [NUM_FLAGS-1:0] flag_mask;
    logic [NUM_FLAGS-1:0] flags;
    logic                 mispredict;
  } rob_entry_t;

  // MSB is the wrap bit distinguishing full from empty
  typedef logic [ROB_IDX_W_DEF:0] rob_ptr_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer driving the register file commit port
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           disp_v_i,
  output logic                           disp_ready_o,
  input  logic                           disp_dest_v_i,
  input  logic [PHYS_W-1:0]              disp_phys_new_i,
  input  logic [PHYS_W-1:0]              disp_phys_old_i,
  input  logic [NUM_FLAGS-1:0]           disp_flag_mask_i,
  output logic [ROB_IDX_W-1:0]           disp_rob_idx_o,
  input  logic [NUM_FU-1:0]              exe_done_v_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0]    exe_rob_idx_i,
  input  logic [NUM_FU*NUM_FLAGS-1:0]    exe_flags_i,
  input  logic [NUM_FU-1:0]              exe_mispredict_i,
  output logic                           rob_phys_valid_o,
  output logic [PHYS_W-1:0]              rob_phys_reg_cl_o,
  output logic [PHYS_W-1:0]              rob_phys_reg_set_o,
  output logic                           rob_phys_mispredict_o,
  output logic                           rob_flag_valid_o,
  output logic [2*NUM_FLAGS-1:0]         rob_flag_i_o,
  output logic                           flush_o
);

  localparam logic [ROB_IDX_W:0] PTR_ONE = {{ROB_IDX_W{1'b0}}, 1'b1};

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];

  logic [ROB_IDX_W:0] head_q, head_d;
  logic [ROB_IDX_W:0] tail_q, tail_d;

  logic                   phys_valid_q, phys_valid_d;
  logic [PHYS_W-1:0]      phys_reg_cl_q, phys_reg_cl_d;
  logic [PHYS_W-1:0]      phys_reg_set_q, phys_reg_set_d;
  logic                   mispredict_q, mispredict_d;
  logic                   flag_valid_q, flag_valid_d;
  logic [2*NUM_FLAGS-1:0] flag_i_q, flag_i_d;

  logic                 full;
  logic                 disp_fire;
  logic                 retire;
  logic                 flush;
  rob_entry_t           head_e;
  logic [ROB_IDX_W-1:0] head_idx;
  logic [ROB_IDX_W-1:0] tail_idx;
  logic [ROB_IDX_W-1:0] exe_idx;

  assign head_idx  = head_q[ROB_IDX_W-1:0];
  assign tail_idx  = tail_q[ROB_IDX_W-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[ROB_IDX_W] != tail_q[ROB_IDX_W]);
  assign disp_fire = disp_v_i && disp_ready_o;
  assign head_e    = rob_q[head_idx];
  assign retire    = head_e.busy && head_e.done;
  assign flush     = retire && head_e.mispredict;

  always_comb begin
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    exe_idx        = '0;
    phys_valid_d   = 1'b0;
    phys_reg_cl_d  = '0;
    phys_reg_set_d = '0;
    mispredict_d   = 1'b0;
    flag_valid_d   = 1'b0;
    flag_i_d       = '0;

    for (int i = 0; i < NUM_FU; i++) begin
      exe_idx = exe_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
      if (exe_done_v_i[i] && rob_q[exe_idx].busy) begin
        rob_d[exe_idx].done       = 1'b1;
        rob_d[exe_idx].flags      = exe_flags_i[i*NUM_FLAGS +: NUM_FLAGS];
        rob_d[exe_idx].mispredict = exe_mispredict_i[i];
      end
    end

    if (disp_fire && !flush) begin
      rob_d[tail_idx].busy       = 1'b1;
      rob_d[tail_idx].done       = 1'b0;
      rob_d[tail_idx].dest_v     = disp_dest_v_i;
      rob_d[tail_idx].phys_new   = disp_phys_new_i;
      rob_d[tail_idx].phys_old   = disp_phys_old_i;
      rob_d[tail_idx].flag_mask  = disp_flag_mask_i;
      rob_d[tail_idx].flags      = '0;
      rob_d[tail_idx].mispredict = 1'b0;
      tail_d                     = tail_q + PTR_ONE;
    end

    if (retire) begin
      rob_d[head_idx].busy = 1'b0;
      head_d               = head_q + PTR_ONE;
      phys_valid_d         = head_e.dest_v && !head_e.mispredict;
      phys_reg_cl_d        = head_e.phys_old;
      phys_reg_set_d       = head_e.phys_new;
      mispredict_d         = head_e.mispredict;
      flag_valid_d         = (head_e.flag_mask != '0);
      flag_i_d             = {head_e.flag_mask, head_e.flags};
    end

    // Squash everything younger than the mispredicted branch; buffer ends empty
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_d[i].busy = 1'b0;
      end
      tail_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rob_q          <= '{default: '0};
      head_q         <= '0;
      tail_q         <= '0;
      phys_valid_q   <= 1'b0;
      phys_reg_cl_q  <= '0;
      phys_reg_set_q <= '0;
      mispredict_q   <= 1'b0;
      flag_valid_q   <= 1'b0;
      flag_i_q       <= '0;
    end else begin
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      phys_valid_q   <= phys_valid_d;
      phys_reg_cl_q  <= phys_reg_cl_d;
      phys_reg_set_q <= phys_reg_set_d;
      mispredict_q   <= mispredict_d;
      flag_valid_q   <= flag_valid_d;
      flag_i_q       <= flag_i_d;
    end
  end

  // Outputs are forced low for the whole time reset is asserted
  assign disp_ready_o          = !full && !reset_i;
  assign disp_rob_idx_o        = reset_i ? '0 : tail_idx;
  assign rob_phys_valid_o      = phys_valid_q && !reset_i;
  assign rob_phys_reg_cl_o     = reset_i ? '0 : phys_reg_cl_q;
  assign rob_phys_reg_set_o    = reset_i ? '0 : phys_reg_set_q;
  assign rob_phys_mispredict_o = mispredict_q && !reset_i;
  assign flush_o               = mispredict_q && !reset_i;
  assign rob_flag_valid_o      = flag_valid_q && !reset_i;
  assign rob_flag_i_o          = reset_i ? '0 : flag_i_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int IW = ROB_IDX_W_DEF;

  logic                        clk_i;
  logic                        reset_i;
  logic                        disp_v_i;
  logic                        disp_ready_o;
  logic                        disp_dest_v_i;
  logic [PHYS_W-1:0]           disp_phys_new_i;
  logic [PHYS_W-1:0]           disp_phys_old_i;
  logic [NUM_FLAGS-1:0]        disp_flag_mask_i;
  logic [IW-1:0]               disp_rob_idx_o;
  logic [NUM_FU-1:0]           exe_done_v_i;
  logic [NUM_FU*IW-1:0]        exe_rob_idx_i;
  logic [NUM_FU*NUM_FLAGS-1:0] exe_flags_i;
  logic [NUM_FU-1:0]           exe_mispredict_i;
  logic                        rob_phys_valid_o;
  logic [PHYS_W-1:0]           rob_phys_reg_cl_o;
  logic [PHYS_W-1:0]           rob_phys_reg_set_o;
  logic                        rob_phys_mispredict_o;
  logic                        rob_flag_valid_o;
  logic [2*NUM_FLAGS-1:0]      rob_flag_i_o;
  logic                        flush_o;

  int errors = 0;
  int checks = 0;

  reorder_buffer dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .disp_v_i              (disp_v_i),
    .disp_ready_o          (disp_ready_o),
    .disp_dest_v_i         (disp_dest_v_i),
    .disp_phys_new_i       (disp_phys_new_i),
    .disp_phys_old_i       (disp_phys_old_i),
    .disp_flag_mask_i      (disp_flag_mask_i),
    .disp_rob_idx_o        (disp_rob_idx_o),
    .exe_done_v_i          (exe_done_v_i),
    .exe_rob_idx_i         (exe_rob_idx_i),
    .exe_flags_i           (exe_flags_i),
    .exe_mispredict_i      (exe_mispredict_i),
    .rob_phys_valid_o      (rob_phys_valid_o),
    .rob_phys_reg_cl_o     (rob_phys_reg_cl_o),
    .rob_phys_reg_set_o    (rob_phys_reg_set_o),
    .rob_phys_mispredict_o (rob_phys_mispredict_o),
    .rob_flag_valid_o      (rob_flag_valid_o),
    .rob_flag_i_o          (rob_flag_i_o),
    .flush_o               (flush_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!reset_i && (&exe_done_v_i) &&
        (exe_rob_idx_i[0 +: IW] == exe_rob_idx_i[IW +: IW])) begin
      errors++;
      $error("FAIL dup_tag observed=%0d expected=distinct", exe_rob_idx_i[0 +: IW]);
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_commit(input string tag, input logic pv, input logic [PHYS_W-1:0] cl,
                            input logic [PHYS_W-1:0] set, input logic fv,
                            input logic [2*NUM_FLAGS-1:0] fi, input logic mp);
    chk({tag, ".phys_valid"}, 32'(rob_phys_valid_o), 32'(pv));
    chk({tag, ".reg_cl"}, 32'(rob_phys_reg_cl_o), 32'(cl));
    chk({tag, ".reg_set"}, 32'(rob_phys_reg_set_o), 32'(set));
    chk({tag, ".flag_valid"}, 32'(rob_flag_valid_o), 32'(fv));
    chk({tag, ".flag_i"}, 32'(rob_flag_i_o), 32'(fi));
    chk({tag, ".mispredict"}, 32'(rob_phys_mispredict_o), 32'(mp));
    chk({tag, ".flush"}, 32'(flush_o), 32'(mp));
  endtask

  task automatic disp(input logic v, input logic dv, input int pnew, input int pold,
                      input logic [NUM_FLAGS-1:0] mask);
    disp_v_i         = v;
    disp_dest_v_i    = dv;
    disp_phys_new_i  = PHYS_W'(pnew);
    disp_phys_old_i  = PHYS_W'(pold);
    disp_flag_mask_i = mask;
  endtask

  task automatic complete(input int fu, input int tag, input logic [NUM_FLAGS-1:0] flags,
                          input logic mp);
    exe_done_v_i[fu]                     = 1'b1;
    exe_rob_idx_i[fu*IW +: IW]           = IW'(tag);
    exe_flags_i[fu*NUM_FLAGS +: NUM_FLAGS] = flags;
    exe_mispredict_i[fu]                 = mp;
  endtask

  task automatic clear_exe;
    exe_done_v_i     = '0;
    exe_rob_idx_i    = '0;
    exe_flags_i      = '0;
    exe_mispredict_i = '0;
  endtask

  initial begin
    reset_i = 1'b1;
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    clear_exe();

    // Reset state
    tick();
    tick();
    chk("rst.ready", 32'(disp_ready_o), 32'd0);
    chk("rst.idx", 32'(disp_rob_idx_o), 32'd0);
    chk_commit("rst", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("post_rst.ready", 32'(disp_ready_o), 32'd1);
    chk("post_rst.idx", 32'(disp_rob_idx_o), 32'd0);

    // Three entries completed out of order retire in tag order
    disp(1'b1, 1'b1, 16, 1, 4'b0000);
    chk("t1.idx0", 32'(disp_rob_idx_o), 32'd0);
    tick();
    disp(1'b1, 1'b1, 17, 2, 4'b0000);
    chk("t1.idx1", 32'(disp_rob_idx_o), 32'd1);
    tick();
    disp(1'b1, 1'b1, 18, 3, 4'b0000);
    chk("t1.idx2", 32'(disp_rob_idx_o), 32'd2);
    tick();
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    complete(0, 2, 4'b0000, 1'b0);
    tick();
    clear_exe();
    complete(0, 0, 4'b0000, 1'b0);
    chk_commit("t1.none0", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    tick();
    clear_exe();
    complete(0, 1, 4'b0000, 1'b0);
    tick();
    clear_exe();
    chk_commit("t1.ret0", 1'b1, 6'd1, 6'd16, 1'b0, 8'h00, 1'b0);
    tick();
    chk_commit("t1.ret1", 1'b1, 6'd2, 6'd17, 1'b0, 8'h00, 1'b0);
    tick();
    chk_commit("t1.ret2", 1'b1, 6'd3, 6'd18, 1'b0, 8'h00, 1'b0);
    tick();
    chk_commit("t1.idle", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    chk("t1.tail", 32'(disp_rob_idx_o), 32'd3);

    // Flag-only entry
    disp(1'b1, 1'b0, 0, 0, 4'b0011);
    tick();
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    complete(1, 3, 4'b0110, 1'b0);
    tick();
    clear_exe();
    tick();
    chk_commit("flag.ret", 1'b0, 6'd0, 6'd0, 1'b1, 8'b0011_0110, 1'b0);
    tick();
    chk("flag.pulse_end", 32'(rob_flag_valid_o), 32'd0);

    // Branch at tag 5 mispredicts while 6..9 are done
    disp(1'b1, 1'b1, 20, 4, 4'b0000);
    chk("br.idx4", 32'(disp_rob_idx_o), 32'd4);
    tick();
    disp(1'b1, 1'b0, 0, 0, 4'b0000);
    tick();
    for (int i = 6; i <= 9; i++) begin
      disp(1'b1, 1'b1, 15 + i, i - 1, 4'b0000);
      chk("br.idx", 32'(disp_rob_idx_o), 32'(i));
      tick();
    end
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    complete(0, 6, 4'b0000, 1'b0);
    complete(1, 7, 4'b0000, 1'b0);
    tick();
    clear_exe();
    complete(0, 8, 4'b0000, 1'b0);
    complete(1, 9, 4'b0000, 1'b0);
    tick();
    clear_exe();
    complete(0, 5, 4'b0000, 1'b1);
    tick();
    clear_exe();
    complete(0, 4, 4'b0000, 1'b0);
    tick();
    clear_exe();
    tick();
    chk_commit("br.ret4", 1'b1, 6'd4, 6'd20, 1'b0, 8'h00, 1'b0);
    disp(1'b1, 1'b1, 30, 9, 4'b0000);
    chk("br.flush_cycle_ready", 32'(disp_ready_o), 32'd1);
    chk("br.flush_cycle_idx", 32'(disp_rob_idx_o), 32'd10);
    tick();
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    chk_commit("br.ret5", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b1);
    chk("br.next_idx", 32'(disp_rob_idx_o), 32'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_commit("br.squashed", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    end
    chk("br.empty_idx", 32'(disp_rob_idx_o), 32'd6);

    // Reset with four busy entries and a completion in flight
    for (int i = 0; i < 4; i++) begin
      disp(1'b1, 1'b1, 40 + i, 10 + i, 4'b0000);
      tick();
    end
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    complete(0, 6, 4'b0000, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("mid_rst.ready", 32'(disp_ready_o), 32'd0);
    tick();
    clear_exe();
    chk("mid_rst.ready2", 32'(disp_ready_o), 32'd0);
    chk_commit("mid_rst", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("mid_rst.after_ready", 32'(disp_ready_o), 32'd1);
    chk("mid_rst.after_idx", 32'(disp_rob_idx_o), 32'd0);
    tick();
    chk_commit("mid_rst.quiet", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);
    complete(0, 0, 4'b0000, 1'b0);
    tick();
    clear_exe();
    tick();
    chk_commit("nonbusy_done", 1'b0, 6'd0, 6'd0, 1'b0, 8'h00, 1'b0);

    // Fill all 32 entries, then free one slot
    for (int i = 0; i < 32; i++) begin
      disp(1'b1, 1'b1, 32 + i, i, 4'b0000);
      chk("fill.idx", 32'(disp_rob_idx_o), 32'(i));
      chk("fill.ready", 32'(disp_ready_o), 32'd1);
      tick();
    end
    disp(1'b1, 1'b1, 63, 63, 4'b0000);
    chk("full.ready", 32'(disp_ready_o), 32'd0);
    complete(0, 0, 4'b0000, 1'b0);
    tick();
    clear_exe();
    chk("full.retire_cycle_ready", 32'(disp_ready_o), 32'd0);
    chk("full.no_commit_yet", 32'(rob_phys_valid_o), 32'd0);
    tick();
    disp(1'b0, 1'b0, 0, 0, 4'b0000);
    chk_commit("full.ret0", 1'b1, 6'd0, 6'd32, 1'b0, 8'h00, 1'b0);
    chk("full.ready_back", 32'(disp_ready_o), 32'd1);
    chk("full.tail_idx", 32'(disp_rob_idx_o), 32'd0);
    chk("full.tail_wrap", 32'(dut.tail_q[IW]), 32'd1);
    tick();
    chk("full.single_retire", 32'(rob_phys_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
